// File: rtl/search_centre_generator.sv
// search_centre_generator: walks every macroblock of a frame, emitting block origin and clamped search-window centre over valid/ready
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, scan_mode                frame start (sampled in IDLE), 0 = column-major / 1 = row-major (latched on start)
//   ready                           downstream accepts the current entry
//   valid, mb_index, last           entry qualifier, sequence number, final-entry flag
//   x_block, y_block                macroblock top-left origin
//   x_centre_reference, y_centre_reference  search centre clamped so the window stays in frame
//   busy, done                      high while scanning, one-cycle pulse after the final transfer
module search_centre_generator #(
  parameter int FRAME_W      = 96,
  parameter int FRAME_H      = 96,
  parameter int MB_SIZE      = 16,
  parameter int SEARCH_RANGE = 16,
  parameter int COORD_W      = 7,
  parameter int IDX_W        = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               scan_mode,
  input  logic               ready,
  output logic               valid,
  output logic [IDX_W-1:0]   mb_index,
  output logic [COORD_W-1:0] x_block,
  output logic [COORD_W-1:0] y_block,
  output logic [COORD_W-1:0] x_centre_reference,
  output logic [COORD_W-1:0] y_centre_reference,
  output logic               last,
  output logic               busy,
  output logic               done
);
  localparam int NC = FRAME_W / MB_SIZE;
  localparam int NR = FRAME_H / MB_SIZE;
  localparam int CW = NC > 1 ? $clog2(NC) : 1;
  localparam int RW = NR > 1 ? $clog2(NR) : 1;
  localparam logic [COORD_W:0]   HALF = (COORD_W+1)'(MB_SIZE / 2);
  localparam logic [COORD_W:0]   LO_W = (COORD_W+1)'(SEARCH_RANGE);
  localparam logic [COORD_W:0]   HX_W = (COORD_W+1)'(FRAME_W - SEARCH_RANGE);
  localparam logic [COORD_W:0]   HY_W = (COORD_W+1)'(FRAME_H - SEARCH_RANGE);
  localparam logic [COORD_W-1:0] LO   = COORD_W'(SEARCH_RANGE);
  localparam logic [COORD_W-1:0] HX   = COORD_W'(FRAME_W - SEARCH_RANGE);
  localparam logic [COORD_W-1:0] HY   = COORD_W'(FRAME_H - SEARCH_RANGE);
  localparam logic [COORD_W-1:0] STEP = COORD_W'(MB_SIZE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic               mode_q, valid_q, busy_q, done_q;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [IDX_W-1:0]   idx_q;
  logic               col_max, row_max, last_d;
  logic [COORD_W:0]   raw_x, raw_y;
  always_comb begin
    col_max = col_q == CW'(NC - 1);
    row_max = row_q == RW'(NR - 1);
    last_d  = valid_q && col_max && row_max;
    raw_x   = {1'b0, x_q} + HALF;
    raw_y   = {1'b0, y_q} + HALF;
    // centres are forced to zero outside RUN so every output reads 0 after reset
    x_centre_reference = !valid_q ? '0 : raw_x < LO_W ? LO : raw_x > HX_W ? HX : raw_x[COORD_W-1:0];
    y_centre_reference = !valid_q ? '0 : raw_y < LO_W ? LO : raw_y > HY_W ? HY : raw_y[COORD_W-1:0];
  end
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign last     = last_d;
  assign mb_index = idx_q;
  assign x_block  = x_q;
  assign y_block  = y_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_q <= RUN;
        mode_q  <= scan_mode;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        col_q   <= '0;
        row_q   <= '0;
        x_q     <= '0;
        y_q     <= '0;
        idx_q   <= '0;
      end
    end else if (state_q == RUN) begin
      if (ready) begin
        if (last_d) begin
          state_q <= DONE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
          // inner axis is rows in column-major mode, columns in row-major mode
          if (!mode_q ? row_max : col_max) begin
            if (!mode_q) begin
              row_q <= '0;
              y_q   <= '0;
              col_q <= col_q + CW'(1);
              x_q   <= x_q + STEP;
            end else begin
              col_q <= '0;
              x_q   <= '0;
              row_q <= row_q + RW'(1);
              y_q   <= y_q + STEP;
            end
          end else if (!mode_q) begin
            row_q <= row_q + RW'(1);
            y_q   <= y_q + STEP;
          end else begin
            col_q <= col_q + CW'(1);
            x_q   <= x_q + STEP;
          end
        end
      end
    end else begin
      done_q  <= 1'b0;
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_search_centre_generator.sv
// tb_search_centre_generator: scoreboard bench for default 96x96 and 64x32 search-centre generators
module tb_search_centre_generator;
  typedef struct packed {
    logic [5:0] idx;
    logic [6:0] xb, yb, xc, yc;
    logic       lst;
  } e_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, scan_mode = 1'b0, ready = 1'b1;
  logic valid, last, busy, done;
  logic [5:0] mb_index;
  logic [6:0] x_block, y_block, xc, yc;
  logic s_start = 1'b0, s_ready = 1'b1;
  logic s_valid, s_last, s_busy, s_done;
  logic [4:0] s_idx;
  logic [6:0] s_xb, s_yb, s_xc, s_yc;
  e_t q0[$], q1[$];
  e_t a0, a1;
  bit p0 = 1'b0, p1 = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  search_centre_generator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scan_mode(scan_mode), .ready(ready),
    .valid(valid), .mb_index(mb_index), .x_block(x_block), .y_block(y_block),
    .x_centre_reference(xc), .y_centre_reference(yc), .last(last), .busy(busy), .done(done)
  );
  search_centre_generator #(.FRAME_W(64), .FRAME_H(32), .MB_SIZE(8), .SEARCH_RANGE(8), .COORD_W(7), .IDX_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .scan_mode(1'b0), .ready(s_ready),
    .valid(s_valid), .mb_index(s_idx), .x_block(s_xb), .y_block(s_yb),
    .x_centre_reference(s_xc), .y_centre_reference(s_yc), .last(s_last), .busy(s_busy), .done(s_done)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic push0(input bit m, input int n);
    int cs[6] = '{16, 24, 40, 56, 72, 80};
    int k = 0, c, r;
    e_t e;
    for (int o = 0; o < 6; o++)
      for (int i = 0; i < 6; i++) begin
        c = m ? i : o;
        r = m ? o : i;
        e = '{idx: 6'(k), xb: 7'(c * 16), yb: 7'(r * 16), xc: 7'(cs[c]), yc: 7'(cs[r]), lst: k == 35};
        if (k < n) q0.push_back(e);
        k++;
      end
  endtask
  task automatic push1();
    int xs[8] = '{8, 12, 20, 28, 36, 44, 52, 56};
    int ys[4] = '{8, 12, 20, 24};
    int k = 0;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++) begin
        q1.push_back('{idx: 6'(k), xb: 7'(c * 8), yb: 7'(r * 8), xc: 7'(xs[c]), yc: 7'(ys[r]), lst: k == 31});
        k++;
      end
  endtask
  task automatic pulse(input bit m);
    @(posedge clk); #1 start = 1'b1; scan_mode = m;
    @(posedge clk); #1 start = 1'b0;
    chk("first_valid", valid, 1);
  endtask
  task automatic drain(input bit rnd, input bit tog);
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < 3000) begin
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      if (tog) begin
        start = q0.size() > 3 ? 1'($urandom_range(0, 1)) : 1'b0;
        scan_mode = 1'($urandom_range(0, 1));
      end
      c++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    ready = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("idle_after_frame", {valid, busy, done, s_valid, s_busy, s_done}, 0);
  endtask
  always @(negedge clk) begin
    if (done || p0) chk("done_pulse0", {done, valid}, {p0, 1'b0});
    if (s_done || p1) chk("done_pulse1", {s_done, s_valid}, {p1, 1'b0});
    p0 = valid && ready && last;
    p1 = s_valid && s_ready && s_last;
    if (valid || busy) chk("busy0", busy, valid);
    if (valid) begin
      a0 = '{idx: mb_index, xb: x_block, yb: y_block, xc: xc, yc: yc, lst: last};
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry0: got idx=%0d x=%0d y=%0d want no entry", mb_index, xc, yc);
      end else begin
        chk("entry0", a0, q0[0]);
        if (ready) void'(q0.pop_front());
      end
    end
    if (s_valid) begin
      a1 = '{idx: 6'(s_idx), xb: s_xb, yb: s_yb, xc: s_xc, yc: s_yc, lst: s_last};
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry1: got idx=%0d want no entry", s_idx);
      end else begin
        chk("entry1", a1, q1[0]);
        if (s_ready) void'(q1.pop_front());
      end
    end
  end
  initial begin
    #1 rst_n = 1'b0;
    #10 chk("reset0", {valid, mb_index, x_block, y_block, xc, yc, last, busy, done}, 0);
    chk("reset1", {s_valid, s_idx, s_xb, s_yb, s_xc, s_yc, s_last, s_busy, s_done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    push0(0, 36);
    pulse(0);
    drain(0, 0);
    push0(1, 36);
    pulse(1);
    drain(0, 1);
    push0(0, 36);
    pulse(0);
    drain(1, 0);
    push0(0, 36);
    @(posedge clk); #1 start = 1'b1; scan_mode = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #2;
      if (done) break;
    end
    chk("done_seen", done, 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("no_restart", {valid, busy, done}, 0);
    chk("hold_q0", q0.size(), 0);
    push0(0, 11);
    pulse(0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      if (valid && mb_index == 6'd10) break;
    end
    chk("abort_at10", {valid, mb_index}, {1'b1, 6'd10});
    rst_n = 1'b0;
    #1 chk("abort_outputs", {valid, mb_index, x_block, y_block, xc, yc, last, busy, done}, 0);
    chk("abort_q0", q0.size(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    push0(0, 36);
    pulse(0);
    drain(0, 0);
    push1();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    chk("first_valid1", s_valid, 1);
    drain(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
